// File: rtl/mclr5_lsu_arbiter.sv
// mclr5_lsu_arbiter: serialises a 4-lane load/store bundle onto one memory port.
// Ports: CORE_CLK/RESET_n; LANE_* bundle in; LANE_RDATA/STALL/BUNDLE_DONE/ERR out; MEM_* port.
module mclr5_lsu_arbiter #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic         CORE_CLK,
  input  logic         RESET_n,
  input  logic [3:0]   LANE_LOAD_REQ,
  input  logic [3:0]   LANE_STORE_REQ,
  input  logic [127:0] LANE_ADDR,
  input  logic [127:0] LANE_WDATA,
  output logic [127:0] LANE_RDATA,
  output logic         STALL,
  output logic         BUNDLE_DONE,
  output logic         MEM_REQ,
  output logic         MEM_WE,
  output logic [31:0]  MEM_ADDR,
  output logic [31:0]  MEM_WDATA,
  input  logic         MEM_ACK,
  input  logic [31:0]  MEM_RDATA,
  output logic         ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_TMO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t         r_state;
  logic [3:0]     r_pend;
  logic [3:0]     r_ld;
  logic [3:0]     r_st;
  logic [127:0]   r_addr;
  logic [127:0]   r_wd;
  logic [1:0]     r_lane;
  logic [15:0]    r_cnt;
  logic           r_mem_req;
  logic           r_mem_we;
  logic [31:0]    r_mem_addr;
  logic [31:0]    r_mem_wdata;
  logic [127:0]   r_rdata;
  logic           r_done;
  logic           r_err;

  logic [3:0]     w_mask;
  logic [3:0]     w_low;
  logic [1:0]     w_sel;
  logic [3:0]     w_rest;
  logic           w_tmo;

  assign w_mask = LANE_LOAD_REQ | LANE_STORE_REQ;
  // Isolate the lowest pending lane as a one-hot vector (program order).
  assign w_low  = r_pend & (~r_pend + 4'd1);
  assign w_rest = r_pend & ~(4'b0001 << r_lane);
  assign w_tmo  = (r_cnt == LP_TMO_LAST);

  always_comb begin
    w_sel = 2'd0;
    unique case (1'b1)
      w_low[0]: w_sel = 2'd0;
      w_low[1]: w_sel = 2'd1;
      w_low[2]: w_sel = 2'd2;
      w_low[3]: w_sel = 2'd3;
      default:  w_sel = 2'd0;
    endcase
  end

  always_ff @(posedge CORE_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_ld        <= '0;
      r_st        <= '0;
      r_addr      <= '0;
      r_wd        <= '0;
      r_lane      <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // Snapshot the whole bundle so later lane changes are harmless.
          if (|w_mask) begin
            r_pend  <= w_mask;
            r_ld    <= LANE_LOAD_REQ;
            r_st    <= LANE_STORE_REQ;
            r_addr  <= LANE_ADDR;
            r_wd    <= LANE_WDATA;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_lane      <= w_sel;
          r_mem_addr  <= r_addr[{w_sel, 5'd0} +: 32];
          r_mem_wdata <= r_wd[{w_sel, 5'd0} +: 32];
          // A lane asking for both is treated as a load and flagged.
          r_mem_we    <= r_st[w_sel] & ~r_ld[w_sel];
          if (r_ld[w_sel] & r_st[w_sel]) r_err <= 1'b1;
          r_mem_req   <= 1'b1;
          r_cnt       <= '0;
          r_state     <= S_WAIT;
        end
        S_WAIT: begin
          if (MEM_ACK) begin
            r_mem_req      <= 1'b0;
            r_pend[r_lane] <= 1'b0;
            if (!r_mem_we) r_rdata[{r_lane, 5'd0} +: 32] <= MEM_RDATA;
            if (|w_rest) begin
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_mem_req <= 1'b0;
            r_pend    <= '0;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign STALL = ((r_state == S_IDLE) && (|w_mask))
               || (r_state == S_ISSUE)
               || (r_state == S_WAIT);

  assign LANE_RDATA  = r_rdata;
  assign BUNDLE_DONE = r_done;
  assign MEM_REQ     = r_mem_req;
  assign MEM_WE      = r_mem_we;
  assign MEM_ADDR    = r_mem_addr;
  assign MEM_WDATA   = r_mem_wdata;
  assign ERR         = r_err;

endmodule

// File: tb/tb_mclr5_lsu_arbiter.sv
// tb_mclr5_lsu_arbiter: randomized bundles, memory responder, queue scoreboard.
// Expected accesses and bundle results come from a lane-order reference model.
module tb_mclr5_lsu_arbiter;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   ld_req;
  logic [3:0]   st_req;
  logic [127:0] l_addr;
  logic [127:0] l_wd;
  logic [127:0] l_rd;
  logic         stall;
  logic         done;
  logic         mreq;
  logic         mwe;
  logic [31:0]  maddr;
  logic [31:0]  mwd;
  logic         mack;
  logic [31:0]  mrd;
  logic         err;

  always #5 clk = ~clk;

  mclr5_lsu_arbiter #(.ACK_TIMEOUT(TMO)) dut (
    .CORE_CLK      (clk),
    .RESET_n       (rst_n),
    .LANE_LOAD_REQ (ld_req),
    .LANE_STORE_REQ(st_req),
    .LANE_ADDR     (l_addr),
    .LANE_WDATA    (l_wd),
    .LANE_RDATA    (l_rd),
    .STALL         (stall),
    .BUNDLE_DONE   (done),
    .MEM_REQ       (mreq),
    .MEM_WE        (mwe),
    .MEM_ADDR      (maddr),
    .MEM_WDATA     (mwd),
    .MEM_ACK       (mack),
    .MEM_RDATA     (mrd),
    .ERR           (err)
  );

  typedef struct {
    logic [31:0] a;
    logic        we;
    logic [31:0] wd;
    int          lat;
    bit          tmo;
  } acc_t;

  typedef struct {
    logic [127:0] rd;
    logic         err;
  } bnd_t;

  acc_t        q_acc[$];
  bnd_t        q_bnd[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_mem[logic [31:0]];
  logic [31:0] e_mem[logic [31:0]];
  logic [31:0] m_rd[4];
  logic        m_err = 1'b0;
  int          lat_cfg = 0;
  bit          tmo_cfg = 1'b0;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] dflt(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(string nm, logic [127:0] a, logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Memory: acks after lat_cfg wait cycles, never when tmo_cfg; junk ack when idle.
  initial begin
    int rcnt;
    rcnt = 0;
    mack = 1'b0;
    mrd  = '0;
    forever begin
      @(negedge clk);
      if (!mreq) begin
        rcnt = 0;
        mack = ($urandom_range(0, 3) == 0);
        mrd  = $urandom;
      end else begin
        if (!tmo_cfg && rcnt >= lat_cfg) begin
          mack = 1'b1;
          if (mwe) e_mem[maddr] = mwd;
          mrd = e_mem.exists(maddr) ? e_mem[maddr] : dflt(maddr);
        end else begin
          mack = 1'b0;
          mrd  = $urandom;
        end
        rcnt++;
      end
    end
  end

  // Monitor: pops an expected access on each MEM_REQ rise, a result on BUNDLE_DONE.
  initial begin
    bit   prev;
    int   len;
    bit   chg;
    acc_t cur;
    bnd_t b;
    prev = 1'b0;
    len  = 0;
    chg  = 1'b0;
    cur  = '{a: 0, we: 0, wd: 0, lat: 0, tmo: 0};
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        prev = 1'b0;
      end else begin
        if (mreq && !prev) begin
          if (q_acc.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_req: got addr %h want no access", maddr);
          end else begin
            cur = q_acc.pop_front();
            chk("req_addr", 128'(maddr), 128'(cur.a));
            chk("req_we", 128'(mwe), 128'(cur.we));
            chk("req_wdata", 128'(mwd), 128'(cur.wd));
          end
          len = 0;
          chg = 1'b0;
        end
        if (mreq) begin
          len++;
          if (maddr !== cur.a || mwe !== cur.we || mwd !== cur.wd) chg = 1'b1;
        end
        if (!mreq && prev) begin
          chk("req_len", 128'(len), 128'(cur.tmo ? TMO : cur.lat + 1));
          chk("req_stable", 128'(chg), 128'(0));
        end
        prev = mreq;
        if (done) begin
          if (q_bnd.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_done: got pulse want none");
          end else begin
            b = q_bnd.pop_front();
            chk("rdata", l_rd, b.rd);
            chk("err", 128'(err), 128'(b.err));
            chk("stall_done", 128'(stall), 128'(0));
            chk("acc_left", 128'(q_acc.size()), 128'(0));
          end
        end
      end
    end
  end

  function automatic logic [31:0] m_read(logic [31:0] a);
    return m_mem.exists(a) ? m_mem[a] : dflt(a);
  endfunction

  // Reference: lanes served lowest first; a timeout ends the bundle after one access.
  task automatic model(input logic [3:0] ld, input logic [3:0] st,
                       input logic [127:0] ad, input logic [127:0] wd,
                       input int lat, input bit tmo);
    acc_t x;
    bnd_t b;
    bit   first;
    first = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if ((ld[n] | st[n]) && !(tmo && !first)) begin
        x.a   = ad[32*n +: 32];
        x.we  = st[n] & ~ld[n];
        x.wd  = wd[32*n +: 32];
        x.lat = lat;
        x.tmo = tmo;
        if (ld[n] & st[n]) m_err = 1'b1;
        if (!tmo) begin
          if (x.we) m_mem[x.a] = x.wd;
          else m_rd[n] = m_read(x.a);
        end
        q_acc.push_back(x);
        first = 1'b0;
      end
    end
    if (tmo) m_err = 1'b1;
    b.rd  = {m_rd[3], m_rd[2], m_rd[1], m_rd[0]};
    b.err = m_err;
    q_bnd.push_back(b);
    lat_cfg = lat;
    tmo_cfg = tmo;
  endtask

  task automatic drive(input logic [3:0] ld, input logic [3:0] st,
                       input logic [127:0] ad, input logic [127:0] wd);
    ld_req = ld;
    st_req = st;
    l_addr = ad;
    l_wd   = wd;
  endtask

  // Scrambles lane inputs while stalled; clears them once the bundle is done.
  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      if (stall) drive(4'($urandom), 4'($urandom),
                       {$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom});
      else drive('0, '0, '0, '0);
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no BUNDLE_DONE want one");
    end
    @(negedge clk);
    drive('0, '0, '0, '0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run(input logic [3:0] ld, input logic [3:0] st,
                     input logic [127:0] ad, input logic [127:0] wd,
                     input int lat, input bit tmo);
    model(ld, st, ad, wd, lat, tmo);
    @(negedge clk);
    drive(ld, st, ad, wd);
    wait_done();
  endtask

  task automatic rand_run(input int nb, input bit bad);
    logic [3:0]   ld;
    logic [3:0]   st;
    logic [127:0] ad;
    logic [127:0] wd;
    int           r;
    for (int b = 0; b < nb; b++) begin
      ld = '0;
      st = '0;
      for (int n = 0; n < 4; n++) begin
        r = $urandom_range(0, 15);
        if (r >= 4 && r < 9) ld[n] = 1'b1;
        else if (r >= 9 && r < 14) st[n] = 1'b1;
        else if (r == 15 && bad) begin
          ld[n] = 1'b1;
          st[n] = 1'b1;
        end
        ad[32*n +: 32] = 32'($urandom_range(0, 15)) << 2;
        wd[32*n +: 32] = $urandom;
      end
      if ((ld | st) == 4'd0) ld[0] = 1'b1;
      run(ld, st, ad, wd, $urandom_range(0, 4),
          bad && ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    drive('0, '0, '0, '0);
    for (int n = 0; n < 4; n++) m_rd[n] = '0;
    m_mem[32'h1000] = 32'hDEAD_BEEF;
    e_mem[32'h1000] = 32'hDEAD_BEEF;
    #3;
    chk("rst_req", 128'(mreq), 128'(0));
    chk("rst_addr", 128'({mwe, maddr, mwd}), 128'(0));
    chk("rst_rdata", l_rd, 128'(0));
    chk("rst_flags", 128'({done, err, stall}), 128'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run(4'b0100, 4'b0000, {32'h0, 32'h1000, 64'h0}, '0, 3, 1'b0);
    run(4'b0001, 4'b1010, {32'h20, 32'h0, 32'h14, 32'h10},
        {32'h55, 32'h0, 32'hAA, 32'h0}, 0, 1'b0);
    run(4'b1111, 4'b0000, {32'h20, 32'h14, 32'h1000, 32'h8}, '0, 0, 1'b0);
    rand_run(25, 1'b0);
    run(4'b0011, 4'b0010, {64'h0, 32'h14, 32'h20}, {64'h0, 32'h99, 32'h0},
        1, 1'b0);
    run(4'b0001, 4'b0100, {32'h0, 32'h30, 32'h0, 32'h1000},
        {32'h0, 32'h77, 64'h0}, 0, 1'b1);
    run(4'b0101, 4'b0010, {32'h0, 32'h1000, 32'h30, 32'h14},
        {64'h0, 32'h66, 32'h0}, 2, 1'b0);
    rand_run(30, 1'b1);

    model(4'b0001, 4'b0000, {96'h0, 32'h3C}, '0, 0, 1'b1);
    @(negedge clk);
    drive(4'b0001, 4'b0000, {96'h0, 32'h3C}, '0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      seen = mreq;
    end
    chk("rst_mid_req_seen", 128'(seen), 128'(1));
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_mem", 128'({mreq, mwe, maddr, mwd}), 128'(0));
    chk("mid_rst_rdata", l_rd, 128'(0));
    chk("mid_rst_flags", 128'({done, err}), 128'(0));
    chk("mid_rst_stall", 128'(stall), 128'(1));
    q_acc.delete();
    q_bnd.delete();
    for (int n = 0; n < 4; n++) m_rd[n] = '0;
    m_err = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("rst_no_done", 128'(seen), 128'(0));
    model(4'b1000, 4'b0001, {32'h1000, 64'h0, 32'h24},
          {96'h0, 32'h1234_5678}, 1, 1'b0);
    @(negedge clk);
    drive(4'b1000, 4'b0001, {32'h1000, 64'h0, 32'h24}, {96'h0, 32'h1234_5678});
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_done();

    repeat (4) @(negedge clk);
    chk("q_acc_empty", 128'(q_acc.size()), 128'(0));
    chk("q_bnd_empty", 128'(q_bnd.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
